prog_timer: RTL and testbench

PROG_TIMER -- requirements
Module: prog_timer

---
 rtl/prog_timer.sv | 177 +++++++++++++++++
 tb/tb_prog_timer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_timer.sv
// ---------------------------------------------------------------------------
// prog_timer -- programmable period timer with one-shot / auto-reload modes.
//
// A load strobe captures the period (max) and mode (periodic). While start
// is held the timer ticks once per cycle in RUN (or once per pre_reg+1 cycles
// when the prescaler is built in). At the last tick of each period it emits
// a registered single-cycle done pulse. One-shot mode then parks in EXPIRED
// until start drops. Dropping start during RUN pauses the count.
//
// Optional feature macro: PROG_TIMER_PRESCALE_EN
//   Adds the prescale input. The value is captured on load and stretches
//   every tick to prescale+1 cycles.
//
// Parameters
//   WIDTH      counter / period width in bits (2..32)
//   PRE_WIDTH  prescaler width in bits
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   load      in   strobe: latch max/periodic(/prescale), clear count, go IDLE
//   max       in   period in ticks (sampled on load)
//   periodic  in   1 = auto-reload, 0 = one-shot (sampled on load)
//   start     in   level run-enable
//   prescale  in   tick divider minus one (PROG_TIMER_PRESCALE_EN only)
//   done      out  one-cycle pulse after each terminal tick
//   busy      out  high in RUN or PAUSE
//   expired   out  high in EXPIRED
//   count     out  current tick count
// ---------------------------------------------------------------------------
module prog_timer #(
  parameter int WIDTH     = 32,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     max,
  input  logic                 periodic,
  input  logic                 start,
`ifdef PROG_TIMER_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] prescale,
`endif
  output logic                 done,
  output logic                 busy,
  output logic                 expired,
  output logic [WIDTH-1:0]     count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     count_q, count_d;
  logic [WIDTH-1:0]     max_q, max_d;
  logic                 mode_q, mode_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 expired_q, expired_d;
  // Without the prescaler, pre_q stays zero, so every RUN cycle is a tick.
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;

  // Next-state, counter, prescaler and output decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    max_d     = max_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    pre_cnt_d = pre_cnt_q;
    done_d    = 1'b0;

    if (load) begin
      // Load overrides any transition, including a terminal tick.
      max_d     = max;
      mode_d    = periodic;
`ifdef PROG_TIMER_PRESCALE_EN
      pre_d     = prescale;
`else
      pre_d     = '0;
`endif
      pre_cnt_d = '0;
      count_d   = '0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero period never starts, so it can never produce done.
          if (start && (max_q != '0)) begin
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          if (!start) begin
            // Pause edge is not a tick; count and prescaler are frozen.
            state_d = PAUSE;
          end else if (pre_cnt_q != pre_q) begin
            pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
          end else begin
            pre_cnt_d = '0;
            if (count_q == (max_q - WIDTH'(1))) begin
              count_d = '0;
              done_d  = 1'b1;
              if (mode_q) begin
                state_d = RUN;
              end else begin
                state_d = EXPIRED;
              end
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end else begin
            state_d = PAUSE;
          end
        end
        EXPIRED: begin
          // One-shot re-arms only after start is released.
          if (!start) begin
            state_d = IDLE;
          end else begin
            state_d = EXPIRED;
          end
        end
        default: begin
          state_d   = IDLE;
          count_d   = '0;
          pre_cnt_d = '0;
        end
      endcase
    end

    busy_d    = (state_d == RUN) || (state_d == PAUSE);
    expired_d = (state_d == EXPIRED);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      max_q     <= '0;
      mode_q    <= 1'b0;
      pre_q     <= '0;
      pre_cnt_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      max_q     <= max_d;
      mode_q    <= mode_d;
      pre_q     <= pre_d;
      pre_cnt_q <= pre_cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
    end
  end

  assign done    = done_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign count   = count_q;

endmodule

// File: tb/tb_prog_timer.sv
// ---------------------------------------------------------------------------
// tb_prog_timer -- self-checking bench for prog_timer.
// Directed scenarios compare against values worked out by hand from the
// timer's rules; a random phase compares every cycle against a reference
// model that tracks elapsed ticks and cycles with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_prog_timer;

  localparam int WIDTH     = 4;
  localparam int PRE_WIDTH = 3;

  logic                 clk;
  logic                 reset;
  logic                 load;
  logic [WIDTH-1:0]     max;
  logic                 periodic;
  logic                 start;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 done;
  logic                 busy;
  logic                 expired;
  logic [WIDTH-1:0]     count;

  int n_checks;
  int n_fail;

  prog_timer #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .max      (max),
    .periodic (periodic),
    .start    (start),
`ifdef PROG_TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .done     (done),
    .busy     (busy),
    .expired  (expired),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase of the timer plus tick / sub-cycle tallies.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
  int m_phase, m_max, m_per, m_pre, m_cnt, m_sub;
  bit m_done;

  task automatic model_edge();
    if (reset) begin
      m_phase = M_IDLE; m_max = 0; m_per = 0; m_pre = 0;
      m_cnt = 0; m_sub = 0; m_done = 0;
    end else if (load) begin
      m_max = int'(max); m_per = int'(periodic);
`ifdef PROG_TIMER_PRESCALE_EN
      m_pre = int'(prescale);
`else
      m_pre = 0;
`endif
      m_cnt = 0; m_sub = 0; m_done = 0; m_phase = M_IDLE;
    end else begin
      m_done = 0;
      case (m_phase)
        M_IDLE:  if (start && m_max != 0) m_phase = M_RUN;
        M_RUN: begin
          if (!start) m_phase = M_PAUSE;
          else begin
            // One tick every m_pre+1 running cycles; period wraps modulo m_max.
            m_sub = (m_sub + 1) % (m_pre + 1);
            if (m_sub == 0) begin
              m_cnt = (m_cnt + 1) % m_max;
              if (m_cnt == 0) begin
                m_done = 1;
                if (m_per == 0) m_phase = M_EXP;
              end
            end
          end
        end
        M_PAUSE: if (start) m_phase = M_RUN;
        default: if (!start) m_phase = M_IDLE;
      endcase
    end
  endtask

  // Advance one clock edge, update the model with the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_load(input int mx, input bit per, input int pre);
    max = WIDTH'(mx); periodic = per; prescale = PRE_WIDTH'(pre);
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; start = 1'b0; max = '0; periodic = 1'b0; prescale = '0;
    step(); step();
    reset = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_checks++; if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired got=%0b exp=0", expired); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
  endtask

  task automatic test_periodic();
    do_load(4, 1'b1, 0);
    start = 1'b1;
    step();  // IDLE -> RUN
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if (done !== ((k % 4) == 0)) begin n_fail++; $display("FAIL periodic_done edge=%0d got=%0b exp=%0b", k, done, (k % 4) == 0); end
      n_checks++;
      if (int'(count) != (k % 4)) begin n_fail++; $display("FAIL periodic_count edge=%0d got=%0d exp=%0d", k, count, k % 4); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL periodic_busy edge=%0d got=%0b exp=1", k, busy); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    do_load(3, 1'b0, 0);
    start = 1'b1;
    step();
    for (int k = 1; k <= 8; k++) begin
      step();
      n_checks++;
      if (done !== (k == 3)) begin n_fail++; $display("FAIL oneshot_done edge=%0d got=%0b exp=%0b", k, done, k == 3); end
      if (k >= 3) begin
        n_checks++;
        if ({expired, busy} !== 2'b10 || count !== 4'd0) begin
          n_fail++; $display("FAIL oneshot_expired edge=%0d got exp=%0b busy=%0b cnt=%0d exp exp=1 busy=0 cnt=0", k, expired, busy, count);
        end
      end
    end
    start = 1'b0;
    step();
    n_checks++;
    if ({expired, busy, done} !== 3'b000) begin n_fail++; $display("FAIL oneshot_idle got exp=%0b busy=%0b done=%0b exp 0 0 0", expired, busy, done); end
  endtask

  task automatic test_pause();
    do_load(10, 1'b1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if (count !== 4'd6) begin n_fail++; $display("FAIL pause_pre_count got=%0d exp=6", count); end
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (busy !== 1'b1 || count !== 4'd6 || done !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold cyc=%0d got busy=%0b cnt=%0d done=%0b exp busy=1 cnt=6 done=0", k, busy, count, done);
      end
    end
    start = 1'b1;
    step();  // PAUSE -> RUN, no tick
    n_checks++;
    if (count !== 4'd6) begin n_fail++; $display("FAIL pause_resume_count got=%0d exp=6", count); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (done !== (k == 4)) begin n_fail++; $display("FAIL pause_resume_done tick=%0d got=%0b exp=%0b", k, done, k == 4); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_max1_max0();
    do_load(1, 1'b1, 0);
    start = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (done !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL max1 edge=%0d got done=%0b cnt=%0d exp done=1 cnt=0", k, done, count); end
    end
    do_load(0, 1'b1, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL max0 edge=%0d got done=%0b busy=%0b exp 0 0", k, done, busy); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    do_load(8, 1'b1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (count !== 4'd5) begin n_fail++; $display("FAIL midrun_count got=%0d exp=5", count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if ({done, busy, expired} !== 3'b000 || count !== 4'd0) begin
      n_fail++; $display("FAIL midrun_reset got done=%0b busy=%0b exp=%0b cnt=%0d exp all 0", done, busy, expired, count);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrun_noload cyc=%0d got busy=%0b done=%0b exp 0 0", k, busy, done); end
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    int peak;
    peak = 0;
    do_load(15, 1'b1, 0);
    start = 1'b1;
    step();
    for (int k = 1; k <= 15; k++) begin
      step();
      if (int'(count) > peak) peak = int'(count);
      n_checks++;
      if (done !== (k == 15)) begin n_fail++; $display("FAIL wrap_done edge=%0d got=%0b exp=%0b", k, done, k == 15); end
    end
    n_checks++;
    if (peak != 14) begin n_fail++; $display("FAIL wrap_peak got=%0d exp=14", peak); end
    n_checks++;
    if (count !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", count); end
    start = 1'b0;
    step();
  endtask

  task automatic test_load_on_terminal();
    do_load(3, 1'b1, 0);
    start = 1'b1;
    step();
    step(); step();
    max = 4'd5; load = 1'b1;  // coincides with the terminal tick
    step();
    load = 1'b0;
    n_checks++;
    if ({done, busy} !== 2'b00 || count !== 4'd0) begin
      n_fail++; $display("FAIL load_terminal got done=%0b busy=%0b cnt=%0d exp 0 0 0", done, busy, count);
    end
    start = 1'b0;
    step();
  endtask

`ifdef PROG_TIMER_PRESCALE_EN
  task automatic test_prescale();
    do_load(4, 1'b1, 2);
    start = 1'b1;
    step();
    for (int k = 1; k <= 24; k++) begin
      step();
      n_checks++;
      if (done !== ((k % 12) == 0)) begin n_fail++; $display("FAIL prescale_done edge=%0d got=%0b exp=%0b", k, done, (k % 12) == 0); end
    end
    for (int k = 0; k < 30; k++) begin
      start = !(k >= 5 && k < 12);
      step();
      n_checks++;
      if (done !== m_done) begin n_fail++; $display("FAIL prescale_pause cyc=%0d got=%0b exp=%0b", k, done, m_done); end
    end
    start = 1'b0;
    step();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(63) == 0);
      load  = ($urandom_range(11) == 0);
      if (load) begin
        max      = ($urandom_range(3) == 0) ? WIDTH'($urandom_range(15)) : WIDTH'($urandom_range(4));
        periodic = 1'($urandom_range(1));
        prescale = PRE_WIDTH'($urandom_range(3));
      end
      if ($urandom_range(7) == 0) start = !start;
      step();
      n_checks++;
      if (done !== m_done) begin n_fail++; $display("FAIL rand_done cyc=%0d got=%0b exp=%0b", c, done, m_done); end
      n_checks++;
      if (busy !== (m_phase == M_RUN || m_phase == M_PAUSE)) begin n_fail++; $display("FAIL rand_busy cyc=%0d got=%0b exp_phase=%0d", c, busy, m_phase); end
      n_checks++;
      if (expired !== (m_phase == M_EXP)) begin n_fail++; $display("FAIL rand_expired cyc=%0d got=%0b exp_phase=%0d", c, expired, m_phase); end
      n_checks++;
      if (int'(count) != m_cnt) begin n_fail++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, count, m_cnt); end
    end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_periodic();
    test_oneshot();
    test_pause();
    test_max1_max0();
    test_reset_midrun();
    test_wrap();
    test_load_on_terminal();
`ifdef PROG_TIMER_PRESCALE_EN
    test_prescale();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
